// File: rtl/mini_alu_pkg.sv
// -----------------------------------------------------------------------------
// mini_alu_pkg
//
// Shared definitions for the mini_alu demo processor:
//   - datapath, address and register-file sizing constants
//   - opcode encodings
//   - bit positions of the fields inside the 28-bit instruction word
//   - mk_instr():    assembles an instruction word from its fields (ROM tables)
//   - alu_result():  value written back to R[DST] for a given opcode
// -----------------------------------------------------------------------------
package mini_alu_pkg;

  // Sizing
  localparam int DATA_W    = 16;   // register / ALU width
  localparam int ADDR_W    = 8;    // PC / ROM address width (256 words)
  localparam int NREGS     = 16;   // register file depth
  localparam int REG_IDX_W = 4;    // low bits of an operand field used as index
  localparam int INSTR_W   = 28;   // instruction word width
  localparam int FIELD_W   = 8;    // width of DST / SRC1 / SRC0 fields
  localparam int LED_W     = 8;    // LED register width

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [3:0]         opcode_t;

  // Opcodes; 8..15 are decoded as NOP.
  localparam opcode_t OP_NOP  = 4'd0;
  localparam opcode_t OP_STO  = 4'd1;
  localparam opcode_t OP_ADD  = 4'd2;
  localparam opcode_t OP_SUB  = 4'd3;
  localparam opcode_t OP_SMUL = 4'd4;
  localparam opcode_t OP_LED  = 4'd5;
  localparam opcode_t OP_BLE  = 4'd6;
  localparam opcode_t OP_JMP  = 4'd7;

  // Instruction field positions: [27:24] op, [23:16] DST, [15:8] SRC1, [7:0] SRC0
  localparam int OPC_MSB  = 27;
  localparam int OPC_LSB  = 24;
  localparam int DST_MSB  = 23;
  localparam int DST_LSB  = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC0_MSB = 7;
  localparam int SRC0_LSB = 0;

  function automatic instr_t mk_instr(input opcode_t            op,
                                      input logic [FIELD_W-1:0] dst,
                                      input logic [FIELD_W-1:0] src1,
                                      input logic [FIELD_W-1:0] src0);
    instr_t w;
    w                    = '0;
    w[OPC_MSB:OPC_LSB]   = op;
    w[DST_MSB:DST_LSB]   = dst;
    w[SRC1_MSB:SRC1_LSB] = src1;
    w[SRC0_MSB:SRC0_LSB] = src0;
    return w;
  endfunction

  // Write-back value for the register-writing opcodes.
  //   a   = R[SRC1], b = R[SRC0], imm = {SRC1,SRC0}
  // SMUL multiplies the signed low bytes; the 8x8 signed product always fits
  // in 16 bits, so no information is lost.
  function automatic logic [DATA_W-1:0] alu_result(input opcode_t           op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] imm);
    logic signed [7:0]        a8;
    logic signed [7:0]        b8;
    logic signed [DATA_W-1:0] prod;
    logic [DATA_W-1:0]        y;
    a8   = a[7:0];
    b8   = b[7:0];
    prod = a8 * b8;
    case (op)
      OP_STO:  y = imm;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SMUL: y = prod;
      default: y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mini_alu_rom.sv
// -----------------------------------------------------------------------------
// mini_alu_rom
//
// Combinational program ROM holding the fixed demo program. Addresses not
// listed hold NOP.
//
// Ports:
//   addr   in   ADDR_W   instruction address (the PC)
//   instr  out  INSTR_W  instruction word at addr
// -----------------------------------------------------------------------------
module mini_alu_rom
  import mini_alu_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output instr_t            instr
);

  always_comb begin
    // NOTE: default assignment first so every path drives instr; without it
    // the unlisted addresses would infer a latch.
    instr = mk_instr(OP_NOP, 8'd0, 8'd0, 8'd0);
    case (addr)
      8'd1:  instr = mk_instr(OP_STO,  8'd1,  8'd0, 8'd3);  // R1 = 3
      8'd2:  instr = mk_instr(OP_STO,  8'd2,  8'd0, 8'd5);  // R2 = 5
      8'd3:  instr = mk_instr(OP_ADD,  8'd3,  8'd1, 8'd2);  // R3 = R1 + R2
      8'd4:  instr = mk_instr(OP_LED,  8'd0,  8'd0, 8'd3);  // LED = R3
      8'd5:  instr = mk_instr(OP_SUB,  8'd4,  8'd2, 8'd1);  // R4 = R2 - R1
      8'd6:  instr = mk_instr(OP_SMUL, 8'd5,  8'd1, 8'd2);  // R5 = R1 * R2
      8'd7:  instr = mk_instr(OP_LED,  8'd0,  8'd0, 8'd5);  // LED = R5
      8'd8:  instr = mk_instr(OP_STO,  8'd6,  8'd0, 8'd1);  // R6 = 1
      8'd9:  instr = mk_instr(OP_ADD,  8'd7,  8'd7, 8'd6);  // R7 = R7 + R6
      8'd10: instr = mk_instr(OP_LED,  8'd0,  8'd0, 8'd7);  // LED = R7
      8'd11: instr = mk_instr(OP_BLE,  8'd9,  8'd7, 8'd2);  // if R7 <= R2 goto 9
      8'd12: instr = mk_instr(OP_JMP,  8'd12, 8'd0, 8'd0);  // halt loop
      default: ;
    endcase
  end

endmodule

// File: rtl/mini_alu.sv
// -----------------------------------------------------------------------------
// mini_alu
//
// Single-cycle mini processor for a board demo: PC, combinational program
// ROM, 16x16 register file and a small ALU (add / sub / signed byte multiply).
// One instruction retires on every rising clock edge; register writes are
// visible to the following instruction. The only visible result is oLed.
//
// Ports:
//   Clock  in   1  system clock, all state changes on the rising edge
//   Reset  in   1  asynchronous active-high reset (PC, LED, registers -> 0)
//   oLed   out  8  LED register, loaded by the LED instruction
// -----------------------------------------------------------------------------
module mini_alu
  import mini_alu_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  output logic [LED_W-1:0] oLed
);

  logic [ADDR_W-1:0]  pc;
  logic [DATA_W-1:0]  regs [NREGS];
  instr_t             instr;

  // Decoded fields
  opcode_t              opcode;
  logic [FIELD_W-1:0]   dst;
  logic [FIELD_W-1:0]   src1;
  logic [FIELD_W-1:0]   src0;
  logic [REG_IDX_W-1:0] dst_idx;
  logic [DATA_W-1:0]    r_src1;
  logic [DATA_W-1:0]    r_src0;

  // Next-state controls
  logic [DATA_W-1:0]  alu_y;
  logic               wr_en;
  logic               led_en;
  logic [ADDR_W-1:0]  pc_next;

  mini_alu_rom u_rom (
    .addr  (pc),
    .instr (instr)
  );

  assign opcode  = instr[OPC_MSB:OPC_LSB];
  assign dst     = instr[DST_MSB:DST_LSB];
  assign src1    = instr[SRC1_MSB:SRC1_LSB];
  assign src0    = instr[SRC0_MSB:SRC0_LSB];
  assign dst_idx = dst[REG_IDX_W-1:0];

  // Register file read ports are asynchronous.
  assign r_src1  = regs[src1[REG_IDX_W-1:0]];
  assign r_src0  = regs[src0[REG_IDX_W-1:0]];

  assign alu_y   = alu_result(opcode, r_src1, r_src0, {src1, src0});

  always_comb begin
    wr_en   = 1'b0;
    led_en  = 1'b0;
    pc_next = pc + 1'b1;          // wraps 255 -> 0 naturally
    case (opcode)
      OP_STO, OP_ADD, OP_SUB, OP_SMUL: wr_en  = 1'b1;
      OP_LED:                          led_en = 1'b1;
      OP_BLE: begin
        // Unsigned compare; equal operands take the branch.
        if (r_src1 <= r_src0) pc_next = dst;
      end
      OP_JMP:                          pc_next = dst;
      default: ;                       // NOP and opcodes 8..15
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // NOTE: the register file must read as zero after reset, so it is built
      // from flops with a reset rather than a RAM macro (which cannot be
      // cleared in one cycle). At 16 entries this is the natural choice.
      pc   <= '0;
      oLed <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would let a write race the same-cycle read.
      pc <= pc_next;
      if (led_en) oLed <= r_src0[LED_W-1:0];
      if (wr_en)  regs[dst_idx] <= alu_y;
    end
  end

endmodule

// File: tb/tb_mini_alu.sv
// -----------------------------------------------------------------------------
// tb_mini_alu
//
// Self-checking bench for mini_alu. An instruction-level interpreter of the
// demo program predicts PC, registers and LED after every edge; fixed values
// from the expected program trace are checked at their edges; the ALU write
// -back function is exercised with corner and random operands against plain
// integer arithmetic. Reset is asserted between edges at random offsets.
// -----------------------------------------------------------------------------
module tb_mini_alu;
  import mini_alu_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] oLed;

  int tests = 0;
  int fails = 0;

  mini_alu dut (
    .Clock (Clock),
    .Reset (Reset),
    .oLed  (oLed)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  int          p_op  [256];
  int          p_dst [256];
  int          p_s1  [256];
  int          p_s0  [256];
  int          m_pc;
  int          m_led;
  logic [15:0] m_r   [16];
  int          edge_n;

  task automatic put(input int a, input int op, input int d, input int s1, input int s0);
    p_op[a] = op; p_dst[a] = d; p_s1[a] = s1; p_s0[a] = s0;
  endtask

  task automatic load_program();
    for (int a = 0; a < 256; a++) put(a, 0, 0, 0, 0);
    put(1, 1, 1, 0, 3);    // STO R1,3
    put(2, 1, 2, 0, 5);    // STO R2,5
    put(3, 2, 3, 1, 2);    // ADD R3,R1,R2
    put(4, 5, 0, 0, 3);    // LED R3
    put(5, 3, 4, 2, 1);    // SUB R4,R2,R1
    put(6, 4, 5, 1, 2);    // SMUL R5,R1,R2
    put(7, 5, 0, 0, 5);    // LED R5
    put(8, 1, 6, 0, 1);    // STO R6,1
    put(9, 2, 7, 7, 6);    // ADD R7,R7,R6
    put(10, 5, 0, 0, 7);   // LED R7
    put(11, 6, 9, 7, 2);   // BLE 9,R7,R2
    put(12, 7, 12, 0, 0);  // JMP 12
  endtask

  function automatic int sbyte(input int v);
    int x;
    x = v % 256;
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic logic [15:0] ref_alu(input int op, input int a, input int b, input int imm);
    case (op)
      1: return 16'(imm);
      2: return 16'((a + b) % 65536);
      3: return 16'(a - b + 65536);
      4: return 16'(sbyte(a) * sbyte(b));
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_led = 0; edge_n = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
  endtask

  task automatic model_step();
    int op, a, b, d, nxt;
    op  = p_op[m_pc];
    d   = p_dst[m_pc] % 16;
    a   = int'(m_r[p_s1[m_pc] % 16]);
    b   = int'(m_r[p_s0[m_pc] % 16]);
    nxt = (m_pc + 1) % 256;
    case (op)
      1, 2, 3, 4: m_r[d] = ref_alu(op, a, b, p_s1[m_pc] * 256 + p_s0[m_pc]);
      5: m_led = b % 256;
      6: if (a <= b) nxt = p_dst[m_pc];
      7: nxt = p_dst[m_pc];
      default: ;
    endcase
    m_pc = nxt;
    edge_n++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic compare_all();
    check($sformatf("e%0d pc", edge_n), 32'(dut.pc), 32'(m_pc));
    check($sformatf("e%0d led", edge_n), 32'(oLed), 32'(m_led));
    for (int i = 0; i < 16; i++)
      check($sformatf("e%0d r%0d", edge_n, i), 32'(dut.regs[i]), 32'(m_r[i]));
  endtask

  // One clock edge: advance the model, sample at the falling edge.
  task automatic step();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    compare_all();
    if (edge_n == 5)  check("trace_add_led", 32'(oLed), 32'd8);
    if (edge_n == 6)  check("trace_sub_r4", 32'(dut.regs[4]), 32'd2);
    if (edge_n == 8)  check("trace_smul_led", 32'(oLed), 32'd15);
    if (edge_n >= 11 && edge_n <= 26 && (edge_n - 11) % 3 == 0)
      check($sformatf("trace_loop_led e%0d", edge_n), 32'(oLed), 32'((edge_n - 11) / 3 + 1));
    if (edge_n == 24) check("ble_equal_taken", 32'(dut.pc), 32'd9);
    if (edge_n >= 27) begin
      check($sformatf("halt_pc e%0d", edge_n), 32'(dut.pc), 32'd12);
      check($sformatf("halt_led e%0d", edge_n), 32'(oLed), 32'd6);
    end
  endtask

  // Assert reset strictly between edges and check outputs clear at once.
  task automatic async_reset(input string tag);
    @(negedge Clock);
    #($urandom_range(1, 3));
    Reset = 1'b1;
    #1;
    check({tag, "_led_now"}, 32'(oLed), 32'd0);
    check({tag, "_pc_now"}, 32'(dut.pc), 32'd0);
    model_reset();
  endtask

  task automatic hold_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge Clock);
      compare_all();
    end
    Reset = 1'b0;   // released at a falling edge; next rising edge is edge 1
  endtask

  initial begin
    int k;
    logic [15:0] a16, b16, i16;
    int op;

    load_program();
    model_reset();

    // Power-on reset, held for 5 cycles
    hold_reset(5);

    // Full program run into the halt loop
    for (int e = 0; e < 40; e++) step();

    // Asynchronous reset from the halted state
    async_reset("async_halt");
    hold_reset(2);

    // Reset in the middle of the loop
    k = $urandom_range(13, 17);
    for (int e = 0; e < k; e++) step();
    async_reset("async_midloop");
    hold_reset(2);

    // Replay of the whole trace, then 30+ halted cycles
    for (int e = 0; e < 60; e++) step();

    // ALU write-back corners
    check("sub_0_minus_1", 32'(alu_result(OP_SUB, 16'h0000, 16'h0001, 16'h0000)), 32'h0000FFFF);
    check("smul_ff_x_02", 32'(alu_result(OP_SMUL, 16'h12FF, 16'h3402, 16'h0000)), 32'h0000FFFE);
    check("add_wrap", 32'(alu_result(OP_ADD, 16'hFFFF, 16'h0002, 16'h0000)), 32'h00000001);
    check("smul_80_x_80", 32'(alu_result(OP_SMUL, 16'h0080, 16'h0080, 16'h0000)), 32'h00004000);

    // Random ALU operands against integer arithmetic
    for (int n = 0; n < 200; n++) begin
      op  = $urandom_range(1, 4);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      i16 = 16'($urandom);
      check($sformatf("alu_rand op%0d %0h %0h", op, a16, b16),
            32'(alu_result(opcode_t'(op), a16, b16, i16)),
            32'(ref_alu(op, int'(a16), int'(b16), int'(i16))));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
